// File: rtl/servant_wb_arbiter_mux.sv
// Wishbone 1-to-N slave multiplexer between the SERV data bus and its peripherals.
// The slave is chosen by the top SEL_BITS of the address. Each slave either returns its
// own ack or is auto-acked by the mux. Unmapped addresses and ack timeouts get an error
// response. Read data is registered, and the mux keeps an error count and the last
// errored address.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_wb_cpu_*             master request (adr, dat, sel, we, cyc)
//   o_wb_cpu_rdt/ack/err   registered response to the master
//   o_wb_s_adr/dat/sel/we  request broadcast to every slave
//   o_wb_s_cyc             per-slave cyc, one-hot or zero
//   i_wb_s_rdt/ack         per-slave response
//   o_err_cnt              saturating count of error responses
//   o_err_adr              address of the most recent errored access
module servant_wb_arbiter_mux #(
  parameter int unsigned                   NUM_SLAVES    = 8,
  parameter int unsigned                   SEL_BITS      = 3,
  parameter logic [(2**SEL_BITS)-1:0]      VALID_MASK    = 8'hFF,
  parameter logic [(2**SEL_BITS)-1:0]      AUTO_ACK_MASK = 8'h1D,
  parameter int unsigned                   TIMEOUT       = 255,
  parameter logic [31:0]                   ERR_DATA      = 32'hDEADBEEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [31:0]                i_wb_cpu_adr,
  input  logic [31:0]                i_wb_cpu_dat,
  input  logic [3:0]                 i_wb_cpu_sel,
  input  logic                       i_wb_cpu_we,
  input  logic                       i_wb_cpu_cyc,
  output logic [31:0]                o_wb_cpu_rdt,
  output logic                       o_wb_cpu_ack,
  output logic                       o_wb_cpu_err,
  output logic [32*NUM_SLAVES-1:0]   o_wb_s_adr,
  output logic [32*NUM_SLAVES-1:0]   o_wb_s_dat,
  output logic [4*NUM_SLAVES-1:0]    o_wb_s_sel,
  output logic [NUM_SLAVES-1:0]      o_wb_s_we,
  output logic [NUM_SLAVES-1:0]      o_wb_s_cyc,
  input  logic [32*NUM_SLAVES-1:0]   i_wb_s_rdt,
  input  logic [NUM_SLAVES-1:0]      i_wb_s_ack,
  output logic [7:0]                 o_err_cnt,
  output logic [31:0]                o_err_adr
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StErr} state_e;

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] idx_q, idx_d;
  logic [15:0]         timer_q, timer_d;
  logic [31:0]         rdt_q, rdt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [31:0]         err_adr_q, err_adr_d;

  logic [SEL_BITS-1:0] adr_idx;
  logic                adr_mapped;
  logic [31:0]         sel_rdt;
  logic                sel_ack;
  logic                sel_auto;
  logic                go_err;

  assign adr_idx    = i_wb_cpu_adr[31 -: SEL_BITS];
  assign adr_mapped = ({{(32-SEL_BITS){1'b0}}, adr_idx} < NUM_SLAVES) && VALID_MASK[adr_idx];

  // Response of the latched slave; loop keeps indexing within the populated ports.
  always_comb begin
    sel_rdt  = '0;
    sel_ack  = 1'b0;
    sel_auto = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_rdt  = i_wb_s_rdt[32*i +: 32];
        sel_ack  = i_wb_s_ack[i];
        sel_auto = AUTO_ACK_MASK[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_wb_s_adr[32*i +: 32] = i_wb_cpu_adr;
      o_wb_s_dat[32*i +: 32] = i_wb_cpu_dat;
      o_wb_s_sel[4*i +: 4]   = i_wb_cpu_sel;
      o_wb_s_we[i]           = i_wb_cpu_we;
      o_wb_s_cyc[i]          = (state_q == StBusy) && i_wb_cpu_cyc && (idx_q == SEL_BITS'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    rdt_d     = rdt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    err_adr_d = err_adr_q;
    go_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_wb_cpu_cyc) begin
          idx_d = adr_idx;
          if (adr_mapped) begin
            state_d = StBusy;
            timer_d = '0;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      StBusy: begin
        if (!i_wb_cpu_cyc) begin
          state_d = StIdle;
        end else if (sel_auto || sel_ack) begin
          // A slave ack in the expiry cycle still wins over the timeout.
          rdt_d   = sel_rdt;
          ack_d   = 1'b1;
          state_d = StResp;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          go_err = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Error response flags are registered on entry so they appear during the ERR cycle.
    if (go_err) begin
      state_d   = StErr;
      ack_d     = 1'b1;
      err_d     = 1'b1;
      rdt_d     = ERR_DATA;
      err_adr_d = i_wb_cpu_adr;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      timer_q   <= '0;
      rdt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      rdt_q     <= rdt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign o_wb_cpu_rdt = rdt_q;
  assign o_wb_cpu_ack = ack_q;
  assign o_wb_cpu_err = err_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_err_adr    = err_adr_q;

endmodule
